// File: rtl/mul16_pkg.sv
// Shared types and constants for the sequential 16-bit shift-add multiplier.
package mul16_pkg;

  localparam int WIDTH   = 16;
  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add16.sv
// Plain 16-bit wrapping adder; the carry out is dropped on purpose.
module add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mul16_seq.sv
// Sequential shift-add multiplier returning the low 16 bits of a*b.
// Define MUL16_EARLY_EXIT_EN to end RUN as soon as the remaining multiplier is zero.
module mul16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] product,
  output logic             out_valid,
  input  logic             out_ready
);
  import mul16_pkg::*;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   product_q, product_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               last_step;

  // A zero addend when the multiplier bit is clear lets the adder run every step.
  assign addend = mplier_q[0] ? mcand_q : '0;

  add16 u_add (
    .a   (acc_q),
    .b   (addend),
    .sum (sum)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    count_d   = count_q;
    last_step = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + COUNT_W'(1);
        last_step = (count_q == {COUNT_W{1'b1}});
`ifdef MUL16_EARLY_EXIT_EN
        if (mplier_d == '0) begin
          last_step = 1'b1;
        end
`else
`endif
        if (last_step) begin
          product_d = sum;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      count_q   <= count_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = product_q;

endmodule

// File: tb/tb_mul16_seq.sv
// Scoreboard bench for mul16_seq; expected latencies follow MUL16_EARLY_EXIT_EN.
module tb_mul16_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] product;
  logic        out_valid;
  logic        out_ready;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  mul16_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Cycles from the accept cycle (cycle 0) to the first cycle showing out_valid.
  function automatic int exp_lat(input logic [15:0] bv);
    int m;
    m = 0;
    for (int i = 0; i < 16; i++) if (bv[i]) m = i + 1;
`ifdef MUL16_EARLY_EXIT_EN
    return ((m == 0) ? 1 : m) + 1;
`else
    return 17 + (m - m);
`endif
  endfunction

  task automatic start_op(input logic [15:0] x, input logic [15:0] y);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end else begin
      exp_q.push_back(16'(x * y));
    end
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) cyc = -1;
  endtask

  function automatic logic [15:0] pop_exp();
    if (exp_q.size() == 0) return 16'hxxxx;
    return exp_q.pop_front();
  endfunction

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a = '0;
    b = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if (product !== 16'h0000) begin bad++; $display("[TB] FAIL reset_product: got %h want 0000", product); end
  endtask

  task automatic test_basic();
    int cyc;
    logic [15:0] e;
    start_op(16'd2, 16'd2);
    total++;
    if (product !== 16'h0000) begin bad++; $display("[TB] FAIL basic_hold_run: got %h want 0000", product); end
    wait_done(cyc);
    e = pop_exp();
    total++;
    if (cyc !== exp_lat(16'd2)) begin bad++; $display("[TB] FAIL basic_latency: got %0d want %0d", cyc, exp_lat(16'd2)); end
    total++;
    if (product !== e) begin bad++; $display("[TB] FAIL basic_product: got %h want %h", product, e); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL basic_in_ready_done: got %b want 0", in_ready); end
    handshake();
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_back_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    total++;
    if (product !== 16'd4) begin bad++; $display("[TB] FAIL basic_hold_idle: got %h want 0004", product); end
  endtask

  task automatic test_corners();
    logic [15:0] ta [7] = '{16'h7FFF, 16'hFFFF, 16'h8000, 16'h5555, 16'h1234, 16'h7777, 16'h0003};
    logic [15:0] tb [7] = '{16'h0002, 16'hFFFF, 16'hFFFF, 16'h0003, 16'h0001, 16'h0000, 16'h8000};
    logic [15:0] tp [7] = '{16'hFFFE, 16'h0001, 16'h8000, 16'hFFFF, 16'h1234, 16'h0000, 16'h8000};
    int cyc;
    logic [15:0] e;
    for (int i = 0; i < 7; i++) begin
      start_op(ta[i], tb[i]);
      wait_done(cyc);
      e = pop_exp();
      total++;
      if (cyc !== exp_lat(tb[i])) begin
        bad++;
        $display("[TB] FAIL corner_latency[%0d]: got %0d want %0d", i, cyc, exp_lat(tb[i]));
      end
      total++;
      if (product !== tp[i] || product !== e) begin
        bad++;
        $display("[TB] FAIL corner_product[%0d]: got %h want %h", i, product, tp[i]);
      end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [15:0] e;
    start_op(16'h1234, 16'h0003);
    wait_done(cyc);
    e = pop_exp();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
      @(negedge clk);
      total++;
      if (product !== e || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++;
        $display("[TB] FAIL stall[%0d]: product=%h in_ready=%b out_valid=%b want %h/0/1", i, product, in_ready, out_valid, e);
      end
    end
    in_valid = 1'b0;
    handshake();
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h369C) begin
      bad++;
      $display("[TB] FAIL stall_release: in_ready=%b out_valid=%b product=%h want 1/0/369c", in_ready, out_valid, product);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    logic [15:0] e;
    start_op(16'h1234, 16'h5678);
    repeat (8) @(negedge clk);
    total++;
    if (product !== 16'h369C || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL run_hold: product=%h out_valid=%b want 369c/0", product, out_valid);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL mid_run_reset: in_ready=%b out_valid=%b product=%h want 1/0/0000", in_ready, out_valid, product);
    end
    start_op(16'd3, 16'd5);
    wait_done(cyc);
    e = pop_exp();
    total++;
    if (product !== 16'd15 || product !== e) begin bad++; $display("[TB] FAIL post_reset_product: got %h want 000f", product); end
    total++;
    if (cyc !== exp_lat(16'd5)) begin bad++; $display("[TB] FAIL post_reset_latency: got %0d want %0d", cyc, exp_lat(16'd5)); end
    handshake();
  endtask

  task automatic test_random();
    int cyc;
    logic [15:0] e;
    logic [15:0] x;
    logic [15:0] y;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if (i % 7 == 3) y = 16'(1) << $urandom_range(15, 0);
      for (int s = 0; s < 2; s++) begin
        if (s == 0) start_op(x, y); else start_op(y, x);
        out_ready = 1'b1;
        wait_done(cyc);
        e = pop_exp();
        total++;
        if (product !== e) begin
          bad++;
          $display("[TB] FAIL random_product[%0d.%0d]: a=%h b=%h got %h want %h", i, s, (s == 0) ? x : y, (s == 0) ? y : x, product, e);
        end
        total++;
        if (cyc !== exp_lat((s == 0) ? y : x)) begin
          bad++;
          $display("[TB] FAIL random_latency[%0d.%0d]: got %0d want %0d", i, s, cyc, exp_lat((s == 0) ? y : x));
        end
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
